// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// mem_bus_arbiter : round-robin share of one strobed memory port by two masters
// Rev 1.0
// ============================================================================
module mem_bus_arbiter #(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 8,
   parameter int WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req_i,
   input  logic              m0_we_i,
   input  logic [ADDR_W-1:0] m0_addr_i,
   input  logic [DATA_W-1:0] m0_wdata_i,
   output logic              m0_ack_o,
   output logic [DATA_W-1:0] m0_rdata_o,
   input  logic              m1_req_i,
   input  logic              m1_we_i,
   input  logic [ADDR_W-1:0] m1_addr_i,
   input  logic [DATA_W-1:0] m1_wdata_i,
   output logic              m1_ack_o,
   output logic [DATA_W-1:0] m1_rdata_o,
   output logic              mem_R_n_o,
   output logic              mem_W_n_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              busy_o,
   output logic              owner_o
);

   localparam int c_cnt_w = $clog2(WAIT_CYCLES + 1);
   localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(WAIT_CYCLES - 1);

   generate
      if (WAIT_CYCLES < 1) begin : g_bad_wait_cycles
         $error("mem_bus_arbiter: WAIT_CYCLES must be >= 1");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                last_gnt_q, last_gnt_d;
   logic                owner_q, owner_d;
   logic                we_q, we_d;
   logic [c_cnt_w-1:0]  cnt_q, cnt_d;
   logic                mem_r_n_q, mem_r_n_d;
   logic                mem_w_n_q, mem_w_n_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic                m0_ack_q, m0_ack_d;
   logic                m1_ack_q, m1_ack_d;
   logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
   logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;
   logic                busy_q, busy_d;

   // A lone requester wins outright; on a tie the port not served last wins.
   logic                w_gnt;
   logic                w_sel_we;
   logic [ADDR_W-1:0]   w_sel_addr;
   logic [DATA_W-1:0]   w_sel_wdata;

   assign w_gnt       = (m0_req_i && m1_req_i) ? ~last_gnt_q : m1_req_i;
   assign w_sel_we    = w_gnt ? m1_we_i    : m0_we_i;
   assign w_sel_addr  = w_gnt ? m1_addr_i  : m0_addr_i;
   assign w_sel_wdata = w_gnt ? m1_wdata_i : m0_wdata_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         last_gnt_q  <= 1'b1;
         owner_q     <= 1'b0;
         we_q        <= 1'b0;
         cnt_q       <= '0;
         mem_r_n_q   <= 1'b1;
         mem_w_n_q   <= 1'b1;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         m0_ack_q    <= 1'b0;
         m1_ack_q    <= 1'b0;
         m0_rdata_q  <= '0;
         m1_rdata_q  <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_gnt_q  <= last_gnt_d;
         owner_q     <= owner_d;
         we_q        <= we_d;
         cnt_q       <= cnt_d;
         mem_r_n_q   <= mem_r_n_d;
         mem_w_n_q   <= mem_w_n_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         m0_ack_q    <= m0_ack_d;
         m1_ack_q    <= m1_ack_d;
         m0_rdata_q  <= m0_rdata_d;
         m1_rdata_q  <= m1_rdata_d;
         busy_q      <= busy_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      last_gnt_d  = last_gnt_q;
      owner_d     = owner_q;
      we_d        = we_q;
      cnt_d       = cnt_q;
      mem_r_n_d   = mem_r_n_q;
      mem_w_n_d   = mem_w_n_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      m0_ack_d    = 1'b0;
      m1_ack_d    = 1'b0;
      m0_rdata_d  = m0_rdata_q;
      m1_rdata_d  = m1_rdata_q;
      busy_d      = busy_q;

      case (state_q)
         ST_IDLE: begin
            if (m0_req_i || m1_req_i) begin
               last_gnt_d = w_gnt;
               owner_d    = w_gnt;
               we_d       = w_sel_we;
               mem_addr_d = w_sel_addr;
               cnt_d      = c_cnt_load;
               busy_d     = 1'b1;
               state_d    = ST_ACCESS;
               if (w_sel_we) begin
                  mem_w_n_d   = 1'b0;
                  mem_wdata_d = w_sel_wdata;
               end else begin
                  mem_r_n_d = 1'b0;
               end
            end
         end

         ST_ACCESS: begin
            // Outputs are registered, so the strobe is released and the ack
            // raised on the edge that ends the last strobe cycle.
            if (cnt_q == '0) begin
               mem_r_n_d = 1'b1;
               mem_w_n_d = 1'b1;
               state_d   = ST_DONE;
               if (owner_q) begin
                  m1_ack_d = 1'b1;
               end else begin
                  m0_ack_d = 1'b1;
               end
               if (!we_q) begin
                  if (owner_q) begin
                     m1_rdata_d = mem_rdata_i;
                  end else begin
                     m0_rdata_d = mem_rdata_i;
                  end
               end
            end else begin
               cnt_d = cnt_q - c_cnt_w'(1);
            end
         end

         ST_DONE: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end

         default: begin
            busy_d    = 1'b0;
            mem_r_n_d = 1'b1;
            mem_w_n_d = 1'b1;
            state_d   = ST_IDLE;
         end
      endcase
   end

   assign m0_ack_o    = m0_ack_q;
   assign m1_ack_o    = m1_ack_q;
   assign m0_rdata_o  = m0_rdata_q;
   assign m1_rdata_o  = m1_rdata_q;
   assign mem_R_n_o   = mem_r_n_q;
   assign mem_W_n_o   = mem_w_n_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign busy_o      = busy_q;
   assign owner_o     = owner_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// tb_mem_bus_arbiter: directed table, corner sequences and randomized traffic,
// all checked cycle by cycle against a transaction-level model of the arbiter.
module tb_mem_bus_arbiter;
   localparam int W1 = 1;
   localparam int W3 = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst = 1'b1;
   logic       m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
   logic [7:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
   logic       m0_ack, m1_ack, mem_R_n, mem_W_n, busy, owner;
   logic [7:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;

   logic       n0_req = 1'b0, n0_we = 1'b0, n1_req = 1'b0, n1_we = 1'b0;
   logic [7:0] n0_addr = '0, n0_wdata = '0, n1_addr = '0, n1_wdata = '0;
   logic       n0_ack, n1_ack, mem3_R_n, mem3_W_n, busy3, owner3;
   logic [7:0] n0_rdata, n1_rdata, mem3_addr, mem3_wdata, mem3_rdata;

   mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(W1)) u_dut (
      .clk(clk), .rst(rst),
      .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
      .m0_ack_o(m0_ack), .m0_rdata_o(m0_rdata),
      .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
      .m1_ack_o(m1_ack), .m1_rdata_o(m1_rdata),
      .mem_R_n_o(mem_R_n), .mem_W_n_o(mem_W_n), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
      .busy_o(busy), .owner_o(owner)
   );

   mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(W3)) u_dut3 (
      .clk(clk), .rst(rst),
      .m0_req_i(n0_req), .m0_we_i(n0_we), .m0_addr_i(n0_addr), .m0_wdata_i(n0_wdata),
      .m0_ack_o(n0_ack), .m0_rdata_o(n0_rdata),
      .m1_req_i(n1_req), .m1_we_i(n1_we), .m1_addr_i(n1_addr), .m1_wdata_i(n1_wdata),
      .m1_ack_o(n1_ack), .m1_rdata_o(n1_rdata),
      .mem_R_n_o(mem3_R_n), .mem_W_n_o(mem3_W_n), .mem_addr_o(mem3_addr),
      .mem_wdata_o(mem3_wdata), .mem_rdata_i(mem3_rdata),
      .busy_o(busy3), .owner_o(owner3)
   );

   function automatic logic [7:0] init_val(int i);
      return (i == 3) ? 8'h78 : 8'(i * 3 + 1);
   endfunction

   // Memories seen by the two arbiters: combinational read, write on strobe.
   logic [7:0] mem  [256];
   logic [7:0] mem3 [256];
   bit         mem_init = 1'b1;
   assign mem_rdata  = mem[mem_addr];
   assign mem3_rdata = mem3[mem3_addr];

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) begin
            mem[i]  <= init_val(i);
            mem3[i] <= init_val(i);
         end
      end else begin
         if (!mem_W_n)  mem[mem_addr]   <= mem_wdata;
         if (!mem3_W_n) mem3[mem3_addr] <= mem3_wdata;
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Transaction-level reference: m_rem counts the non-idle cycles still ahead
   // (WAIT_CYCLES strobe cycles followed by one ack cycle).
   int         m_rem   = 0;
   logic       m_last  = 1'b1;
   logic       m_owner = 1'b0;
   logic       m_we    = 1'b0;
   logic [7:0] m_addr  = '0, m_wdata = '0, m_pend = '0;
   logic [7:0] m_rdata [2];
   logic [7:0] ref_mem [256];

   task automatic model_edge();
      logic g;
      if (rst) begin
         m_rem      = 0;
         m_last     = 1'b1;
         m_owner    = 1'b0;
         m_rdata[0] = '0;
         m_rdata[1] = '0;
      end else if (m_rem == 0) begin
         if (m0_req || m1_req) begin
            if (m0_req && m1_req) g = ~m_last;
            else                  g = m1_req;
            m_last  = g;
            m_owner = g;
            m_we    = g ? m1_we    : m0_we;
            m_addr  = g ? m1_addr  : m0_addr;
            m_wdata = g ? m1_wdata : m0_wdata;
            if (m_we) ref_mem[m_addr] = m_wdata;
            else      m_pend = ref_mem[m_addr];
            m_rem = W1 + 1;
         end
      end else begin
         m_rem--;
         if (m_rem == 1 && !m_we) m_rdata[m_owner] = m_pend;
      end
   endtask

   task automatic cycle();
      bit strobe;
      @(posedge clk);
      model_edge();
      #1;
      strobe = (m_rem >= 2);
      chk("mem_R_n", mem_R_n, !(strobe && !m_we));
      chk("mem_W_n", mem_W_n, !(strobe && m_we));
      chk("one_strobe", mem_R_n | mem_W_n, 1'b1);
      if (strobe) chk("mem_addr", mem_addr, m_addr);
      if (strobe && m_we) chk("mem_wdata", mem_wdata, m_wdata);
      chk("m0_ack", m0_ack, (m_rem == 1) && !m_owner);
      chk("m1_ack", m1_ack, (m_rem == 1) && m_owner);
      chk("m0_rdata", m0_rdata, m_rdata[0]);
      chk("m1_rdata", m1_rdata, m_rdata[1]);
      chk("busy", busy, m_rem != 0);
      chk("owner", owner, m_owner);
   endtask

   typedef struct {
      bit         port;
      bit         we;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] exp_rdata;
      int         exp_lat;
   } vec_t;

   task automatic do_txn(input vec_t v);
      int lat = 0;
      int low = 0;
      bit got = 1'b0;
      if (v.port) begin
         m1_req = 1'b1; m1_we = v.we; m1_addr = v.addr; m1_wdata = v.wdata;
      end else begin
         m0_req = 1'b1; m0_we = v.we; m0_addr = v.addr; m0_wdata = v.wdata;
      end
      while (!got && lat < 20) begin
         cycle();
         lat++;
         if ((v.we ? mem_W_n : mem_R_n) == 1'b0) begin
            low++;
            chk("txn_addr", mem_addr, v.addr);
            if (v.we) chk("txn_wdata", mem_wdata, v.wdata);
         end
         got = v.port ? m1_ack : m0_ack;
      end
      m0_req = 1'b0;
      m1_req = 1'b0;
      chk("txn_latency", lat, v.exp_lat);
      chk("txn_strobe_len", low, 1);
      chk("txn_rdata", v.port ? m1_rdata : m0_rdata, v.exp_rdata);
      cycle();
   endtask

   task automatic drain();
      for (int c = 0; c < 12; c++) begin
         cycle();
         if (m0_ack) m0_req = 1'b0;
         if (m1_ack) m1_req = 1'b0;
      end
      chk("drain_idle", busy, 1'b0);
   endtask

   vec_t vecs [7];
   int   n, lat, low;
   bit   got, wait0, wait1;

   initial begin
      vecs[0] = '{port:1'b0, we:1'b0, addr:8'h03, wdata:8'h00, exp_rdata:8'h78, exp_lat:2};
      vecs[1] = '{port:1'b1, we:1'b1, addr:8'h10, wdata:8'hA5, exp_rdata:8'h00, exp_lat:2};
      vecs[2] = '{port:1'b0, we:1'b0, addr:8'h10, wdata:8'h00, exp_rdata:8'hA5, exp_lat:2};
      vecs[3] = '{port:1'b1, we:1'b0, addr:8'h03, wdata:8'h00, exp_rdata:8'h78, exp_lat:2};
      vecs[4] = '{port:1'b0, we:1'b1, addr:8'h03, wdata:8'h3C, exp_rdata:8'hA5, exp_lat:2};
      vecs[5] = '{port:1'b1, we:1'b0, addr:8'h03, wdata:8'h00, exp_rdata:8'h3C, exp_lat:2};
      vecs[6] = '{port:1'b0, we:1'b0, addr:8'hFF, wdata:8'h00, exp_rdata:8'hFE, exp_lat:2};
      for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);

      // Reset
      rst = 1'b1;
      cycle();
      cycle();
      mem_init = 1'b0;
      chk("rst_R_n", mem_R_n, 1'b1);
      chk("rst_W_n", mem_W_n, 1'b1);
      chk("rst_addr", mem_addr, 8'h00);
      chk("rst_wdata", mem_wdata, 8'h00);
      chk("rst_acks", {m0_ack, m1_ack}, 2'b00);
      chk("rst_rdata", {m0_rdata, m1_rdata}, 16'h0000);
      chk("rst_busy", busy, 1'b0);
      chk("rst_owner", owner, 1'b0);
      rst = 1'b0;
      cycle();

      foreach (vecs[i]) do_txn(vecs[i]);

      // Continuous contention alternates grants starting with port 0
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 8'h21;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 8'h42;
      n = 0;
      for (int c = 0; c < 60 && n < 8; c++) begin
         cycle();
         if (m0_ack || m1_ack) begin
            chk("rr_order", m1_ack, n % 2);
            n++;
         end
      end
      chk("rr_count", n, 8);
      m0_req = 1'b0;
      m1_req = 1'b0;
      cycle();
      cycle();

      // Reset in the middle of an access, then a tie goes to port 0
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 8'h05;
      cycle();
      chk("abort_strobe_low", mem_R_n, 1'b0);
      rst = 1'b1;
      cycle();
      chk("abort_R_n", mem_R_n, 1'b1);
      chk("abort_busy", busy, 1'b0);
      chk("abort_no_ack", {m0_ack, m1_ack}, 2'b00);
      rst = 1'b0;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 8'h06;
      cycle();
      chk("tie_after_rst_owner", owner, 1'b0);
      chk("tie_after_rst_addr", mem_addr, 8'h05);
      drain();

      // Randomized traffic from both ports
      wait0 = 1'b0;
      wait1 = 1'b0;
      for (int c = 0; c < 600; c++) begin
         cycle();
         if (m0_ack) begin
            m0_req = 1'b0; wait0 = 1'b0;
         end else if (wait0) begin
            if (m_rem >= 2 && !m_owner) begin
               m0_addr = 8'($urandom); m0_wdata = 8'($urandom); m0_we = 1'($urandom);
               if ($urandom_range(0, 7) == 0) m0_req = 1'b0;
            end
         end else if ($urandom_range(0, 2) == 0) begin
            m0_req = 1'b1; m0_we = 1'($urandom);
            m0_addr = 8'($urandom_range(0, 15)); m0_wdata = 8'($urandom); wait0 = 1'b1;
         end
         if (m1_ack) begin
            m1_req = 1'b0; wait1 = 1'b0;
         end else if (wait1) begin
            if (m_rem >= 2 && m_owner) begin
               m1_addr = 8'($urandom); m1_wdata = 8'($urandom); m1_we = 1'($urandom);
               if ($urandom_range(0, 7) == 0) m1_req = 1'b0;
            end
         end else if ($urandom_range(0, 2) == 0) begin
            m1_req = 1'b1; m1_we = 1'($urandom);
            m1_addr = 8'($urandom_range(0, 15)); m1_wdata = 8'($urandom); wait1 = 1'b1;
         end
      end
      m0_req = 1'b0;
      m1_req = 1'b0;
      drain();

      // Three wait cycles; address changed during the access is ignored
      n0_req = 1'b1; n0_we = 1'b0; n0_addr = 8'h03;
      lat = 0;
      low = 0;
      got = 1'b0;
      while (!got && lat < 12) begin
         cycle();
         lat++;
         if (lat == 1) n0_addr = 8'h44;
         if (!mem3_R_n) begin
            low++;
            chk("w3_addr", mem3_addr, 8'h03);
         end
         chk("w3_no_write", mem3_W_n, 1'b1);
         chk("w3_busy", busy3, 1'b1);
         got = n0_ack;
      end
      n0_req = 1'b0;
      chk("w3_strobe_len", low, 3);
      chk("w3_ack_cycle", lat, 4);
      chk("w3_rdata", n0_rdata, 8'h78);
      chk("w3_owner", owner3, 1'b0);
      chk("w3_other_port", {n1_ack, n1_rdata}, 9'h000);
      cycle();
      chk("w3_ack_pulse", n0_ack, 1'b0);
      chk("w3_idle", busy3, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
